pkt_rr_mux: RTL

Multi-channel packet multiplexer for the pkt interface family. It accepts NUM_CH independent packet streams, each framed with sof/eof, and buffers each stream in a per-channel FIFO. It merges the streams onto one output stream using packet-granular round-robin arbitration, so a packet is never interleaved with another. It sits between pkt sources and a single pkt sink, and generalises the single-channel pkt path in channel count, width and buffering depth.

---
 rtl/pkt_pkg_hdl.sv | 18 +
 rtl/pkt_sync_fifo.sv | 48 ++++
 rtl/pkt_rr_mux.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pkt_pkg_hdl.sv
// Shared types for the pkt interface family: mux FSM states, channel index width
// helper and the generic beat layout {sof, eof, data}.
`ifndef PKT_BEAT_T
`define PKT_BEAT_T(W) struct packed { logic sof; logic eof; logic [(W)-1:0] data; }
`endif

package pkt_pkg_hdl;

    typedef enum logic {
        PKT_MUX_IDLE,
        PKT_MUX_BURST
    } pkt_mux_state_e;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pkt_sync_fifo.sv
// Single-clock FIFO with combinational head; push is accepted when full if a pop
// happens in the same cycle.
module pkt_sync_fifo #(
    parameter int unsigned W     = 18,
    parameter int unsigned DEPTH = 8
) (
    input  logic         pclk,
    input  logic         prst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_wr, do_rd;

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = do_wr ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        head     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge pclk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pkt_rr_mux.sv
// Packet-granular round-robin multiplexer: per-channel FIFOs merged onto one
// output stream without interleaving packets; orphan beats are dropped in IDLE.
module pkt_rr_mux
    import pkt_pkg_hdl::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                       pclk,
    input  logic                       prst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_sof,
    input  logic [NUM_CH-1:0]          in_eof,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_sof,
    output logic                       out_eof,
    output logic [$clog2(NUM_CH)-1:0]  out_ch,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic [CNT_W-1:0]           orphan_cnt
);
    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    typedef `PKT_BEAT_T(DATA_W) beat_t;
    localparam int unsigned BEAT_W = $bits(beat_t);

    pkt_mux_state_e        state_q, state_d;
    logic [CH_W-1:0]       grant_q, grant_d;
    logic [CH_W-1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]      orphan_cnt_q, orphan_cnt_d;
    logic                  rdy_q;

    logic [NUM_CH-1:0]     full, empty, wr_en, rd_en;
    beat_t [NUM_CH-1:0]    head;
    logic                  found;
    logic [CH_W-1:0]       scan_idx, cand;

    // in_ready stays low until the first edge after reset release.
    assign in_ready   = rdy_q ? ~full : '0;
    assign wr_en      = in_valid & in_ready;
    assign pkt_cnt    = pkt_cnt_q;
    assign orphan_cnt = orphan_cnt_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
        pkt_sync_fifo #(
            .W     (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .pclk    (pclk),
            .prst_n  (prst_n),
            .wr_en   (wr_en[c]),
            .wr_data ({in_sof[c], in_eof[c], in_data[c*DATA_W +: DATA_W]}),
            .rd_en   (rd_en[c]),
            .full    (full[c]),
            .empty   (empty[c]),
            .head    (head[c])
        );
    end

    // First non-empty channel after last_grant in round-robin order.
    always_comb begin
        found    = 1'b0;
        cand     = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            scan_idx = CH_W'((32'(last_grant_q) + i) % NUM_CH);
            if (!found && !empty[scan_idx]) begin
                found = 1'b1;
                cand  = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_cnt_d    = pkt_cnt_q;
        orphan_cnt_d = orphan_cnt_q;
        rd_en        = '0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_sof      = 1'b0;
        out_eof      = 1'b0;
        out_ch       = '0;

        case (state_q)
            PKT_MUX_IDLE: begin
                if (found) begin
                    if (head[cand].sof) begin
                        grant_d = cand;
                        state_d = PKT_MUX_BURST;
                    end else begin
                        rd_en[cand]  = 1'b1;
                        orphan_cnt_d = orphan_cnt_q + CNT_W'(1);
                    end
                end
            end
            PKT_MUX_BURST: begin
                // Only eof closes a packet; a stray sof mid-burst is forwarded.
                if (!empty[grant_q]) begin
                    out_valid = 1'b1;
                    out_data  = head[grant_q].data;
                    out_sof   = head[grant_q].sof;
                    out_eof   = head[grant_q].eof;
                    out_ch    = grant_q;
                    if (out_ready) begin
                        rd_en[grant_q] = 1'b1;
                        if (head[grant_q].eof) begin
                            last_grant_d = grant_q;
                            pkt_cnt_d    = pkt_cnt_q + CNT_W'(1);
                            state_d      = PKT_MUX_IDLE;
                        end
                    end
                end
            end
            default: state_d = PKT_MUX_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q      <= PKT_MUX_IDLE;
            grant_q      <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            pkt_cnt_q    <= '0;
            orphan_cnt_q <= '0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
            orphan_cnt_q <= orphan_cnt_d;
            rdy_q        <= 1'b1;
        end
    end

endmodule
